// File: rtl/sort4_alu_ctrl.sv
// sort4_alu_ctrl: sequential 4-entry bubble sorter driving an external combinational ALU for compares
module sort4_alu_ctrl #(
  parameter int WIDTH   = 4,
  parameter bit SIGNED  = 1'b0,
  parameter bit DESCEND = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] x0_i,
  input  logic [WIDTH-1:0] x1_i,
  input  logic [WIDTH-1:0] x2_i,
  input  logic [WIDTH-1:0] x3_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] s0_o,
  output logic [WIDTH-1:0] s1_o,
  output logic [WIDTH-1:0] s2_o,
  output logic [WIDTH-1:0] s3_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [2:0]       alu_m_o,
  input  logic [WIDTH-1:0] alu_y_i,
  input  logic             alu_cf_i,
  input  logic             alu_of_i,
  input  logic             alu_zf_i
);
  typedef enum logic {IDLE, SORT} state_t;
  state_t           state_q, state_d;
  logic [2:0]       step_q, step_d;
  logic [WIDTH-1:0] r_q [4];
  logic [WIDTH-1:0] r_d [4];
  logic             busy_q, busy_d, done_q, done_d;
  logic [1:0]       j, k;
  logic             lt;
  logic             unused_dbg;
  // zero flag and low result bits are carried for debug only
  assign unused_dbg = ^{alu_zf_i, alu_y_i};
  assign j = (state_q == IDLE) ? 2'd0 :
             (step_q == 3'd1 || step_q == 3'd4) ? 2'd1 :
             (step_q == 3'd2) ? 2'd2 : 2'd0;
  assign k = j + 2'd1;
  // ALU computes a-b; a<b means the pair is out of order in either direction
  assign alu_a_o = DESCEND ? r_q[j] : r_q[k];
  assign alu_b_o = DESCEND ? r_q[k] : r_q[j];
  assign alu_m_o = 3'b001;
  assign lt      = SIGNED ? (alu_y_i[WIDTH-1] ^ alu_of_i) : alu_cf_i;
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    r_d     = r_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (state_q == IDLE && start_i) begin
      r_d     = '{x0_i, x1_i, x2_i, x3_i};
      step_d  = 3'd0;
      busy_d  = 1'b1;
      state_d = SORT;
    end else if (state_q == SORT) begin
      r_d[j] = lt ? r_q[k] : r_q[j];
      r_d[k] = lt ? r_q[j] : r_q[k];
      step_d = step_q + 3'd1;
      if (step_q == 3'd5) begin
        step_d  = 3'd0;
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= 3'd0;
      r_q     <= '{default: '0};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign s0_o   = r_q[0];
  assign s1_o   = r_q[1];
  assign s2_o   = r_q[2];
  assign s3_o   = r_q[3];
endmodule
